// File: rtl/dyser_recv_pkg.sv
// Shared definitions for the DySER receive collector: FSM encoding, port-index
// width and default watchdog limit.
package dyser_recv_pkg;

   localparam int PORT_W              = 5;
   localparam int TIMEOUT_CYC_DEFAULT = 1024;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/dyser_recv_collector_if.sv
// Fabric receive port and host result stream of the collector.
// Handshake: a host beat transfers on a rising clk edge where out_valid and
// out_ready are both 1; out_data/out_last hold steady while out_valid & !out_ready.
interface dyser_recv_collector_if
   import dyser_recv_pkg::*;
#(
   parameter int DW = 32
);
   logic [PORT_W-1:0] recv_port_r0;
   logic [PORT_W-1:0] recv_port_r1;
   logic              recv_en0;
   logic              recv_en1;
   logic              recv_stall;
   logic [DW-1:0]     recv_data_r0;
   logic [DW-1:0]     recv_data_r1;
   logic              out_valid;
   logic              out_ready;
   logic [2*DW-1:0]   out_data;
   logic              out_last;

   modport master (
      output recv_port_r0, recv_port_r1, recv_en0, recv_en1,
      input  recv_stall, recv_data_r0, recv_data_r1,
      output out_valid, out_data, out_last,
      input  out_ready
   );

   modport slave (
      input  recv_port_r0, recv_port_r1, recv_en0, recv_en1,
      output recv_stall, recv_data_r0, recv_data_r1,
      input  out_valid, out_data, out_last,
      output out_ready
   );
endinterface

// File: rtl/recv_fifo.sv
// First-word-fall-through FIFO: the head entry is visible the cycle after it is
// written; reading it is combinational. The caller never pushes when full.
module recv_fifo #(
   parameter int W     = 65,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_pop;

   assign empty  = (count_q == '0);
   assign do_pop = pop & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push)   wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
   end

   // Gate the head so stale storage never shows on the bus while empty.
   assign rdata = empty ? '0 : mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/dyser_recv_collector.sv
// Drives the DySER fabric receive ports for a programmed number of beats and
// streams captured result pairs to the host. Optional stall watchdog: DYSER_RECV_TIMEOUT_EN.
module dyser_recv_collector
   import dyser_recv_pkg::*;
#(
   parameter int DW          = 32,
   parameter int DEPTH       = 4,
   parameter int CNT_W       = 16,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [PORT_W-1:0]      cfg_port0,
   input  logic [PORT_W-1:0]      cfg_port1,
   input  logic                   cfg_dual,
   input  logic [CNT_W-1:0]       cfg_beats,
   dyser_recv_collector_if.master bus,
   output logic                   busy,
   output logic                   run_done,
   output logic                   err,
   output state_e                 dbg_state
);
   localparam int CW = $clog2(DEPTH) + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("dyser_recv_collector: DEPTH must be a power of two >= 2, TIMEOUT_CYC >= 1");
   end

   state_e            state_q, state_d;
   logic [PORT_W-1:0] port0_q, port0_d;
   logic [PORT_W-1:0] port1_q, port1_d;
   logic              dual_q, dual_d;
   logic [CNT_W-1:0]  beats_q, beats_d;
   logic              err_q, err_d;

   logic [CW-1:0]     fifo_count;
   logic              fifo_empty;
   logic [2*DW:0]     fifo_wdata;
   logic [2*DW:0]     fifo_rdata;
   logic              recv_en0;
   logic              beat_done;
   logic              timeout_hit;

   // A beat is only offered while a FIFO slot is guaranteed, so a stalled beat
   // keeps its enable: the count can only fall while nothing is written.
   assign recv_en0  = (state_q == ST_RECV) && (fifo_count < CW'(DEPTH));
   assign beat_done = recv_en0 & ~bus.recv_stall;

`ifdef DYSER_RECV_TIMEOUT_EN
   localparam int SW = $clog2(TIMEOUT_CYC + 1);
   logic [SW-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = '0;
      timeout_hit = 1'b0;
      if (recv_en0 && bus.recv_stall) begin
         if (stall_cnt_q == SW'(TIMEOUT_CYC - 1)) timeout_hit = 1'b1;
         else                                     stall_cnt_d = stall_cnt_q + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) stall_cnt_q <= '0;
      else      stall_cnt_q <= stall_cnt_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      port0_d = port0_q;
      port1_d = port1_q;
      dual_d  = dual_q;
      beats_d = beats_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               port0_d = cfg_port0;
               port1_d = cfg_port1;
               dual_d  = cfg_dual;
               beats_d = cfg_beats;
               err_d   = 1'b0;
               state_d = (cfg_beats == '0) ? ST_DONE : ST_RECV;
            end
         end
         ST_RECV: begin
            if (timeout_hit) begin
               err_d   = 1'b1;
               state_d = fifo_empty ? ST_DONE : ST_DRAIN;
            end else if (beat_done) begin
               beats_d = beats_q - CNT_W'(1);
               if (beats_q == CNT_W'(1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         port0_q <= '0;
         port1_q <= '0;
         dual_q  <= 1'b0;
         beats_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         port0_q <= port0_d;
         port1_q <= port1_d;
         dual_q  <= dual_d;
         beats_q <= beats_d;
         err_q   <= err_d;
      end
   end

   assign fifo_wdata = {beats_q == CNT_W'(1),
                        dual_q ? bus.recv_data_r1 : {DW{1'b0}},
                        bus.recv_data_r0};

   recv_fifo #(
      .W     (2*DW + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (beat_done),
      .wdata (fifo_wdata),
      .pop   (bus.out_ready),
      .rdata (fifo_rdata),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bus.recv_port_r0 = port0_q;
   assign bus.recv_port_r1 = port1_q;
   assign bus.recv_en0     = recv_en0;
   assign bus.recv_en1     = recv_en0 & dual_q;
   assign bus.out_valid    = ~fifo_empty;
   assign bus.out_data     = fifo_rdata[2*DW-1:0];
   // After a watchdog abort no stored entry carries the marker; flag the survivor.
   assign bus.out_last     = fifo_rdata[2*DW] |
                             (err_q && state_q == ST_DRAIN && fifo_count == CW'(1));

   assign busy      = (state_q == ST_RECV) || (state_q == ST_DRAIN);
   assign run_done  = (state_q == ST_DONE);
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_dyser_recv_collector.sv
// Self-checking bench for dyser_recv_collector: fabric model feeds a scoreboard
// queue, host side pops and compares. Timeout scenario built with DYSER_RECV_TIMEOUT_EN.
module tb_dyser_recv_collector;
   import dyser_recv_pkg::*;

   localparam int DW     = 32;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 16;
   localparam int TO_CYC = 16;

   logic              clk       = 1'b0;
   logic              rst       = 1'b1;
   logic              start     = 1'b0;
   logic [PORT_W-1:0] cfg_port0 = '0;
   logic [PORT_W-1:0] cfg_port1 = '0;
   logic              cfg_dual  = 1'b0;
   logic [CNT_W-1:0]  cfg_beats = '0;
   logic              busy, run_done, err;
   state_e            dbg_state;

   dyser_recv_collector_if #(.DW(DW)) bus ();

   dyser_recv_collector #(
      .DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_port0(cfg_port0), .cfg_port1(cfg_port1), .cfg_dual(cfg_dual), .cfg_beats(cfg_beats),
      .bus(bus), .busy(busy), .run_done(run_done), .err(err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            errors = 0;
   logic [2*DW:0] exp_q[$];

   int              beat_idx = 0;
   int              beats_m  = 0;
   bit              dual_m   = 1'b0;
   logic [DW-1:0]   base0    = '0;
   logic [DW-1:0]   base1    = '0;
   int              n_out, n_last;
   bit              en0_seen, en1_seen, hold_ok;
   logic [2*DW-1:0] hold_data, first_data;
   logic [DW-1:0]   upper_or;

   assign bus.recv_data_r0 = base0 + DW'(beat_idx);
   assign bus.recv_data_r1 = base1 + DW'(beat_idx);

   // fabric model + host scoreboard, sampled on the falling edge
   initial begin : monitor
      logic [2*DW:0] got, exp;
      logic [DW-1:0] e_hi, e_lo;
      bit            e_last, fire;
      forever begin
         @(negedge clk);
         fire = 1'b0;
         if (rst) begin
            if (bus.recv_en0) en0_seen = 1'b1;
            if (bus.recv_en1) en1_seen = 1'b1;
            if (bus.recv_en0 && !bus.recv_stall) begin
               fire   = 1'b1;
               e_last = (beat_idx == beats_m - 1);
               e_lo   = base0 + DW'(beat_idx);
               e_hi   = dual_m ? base1 + DW'(beat_idx) : {DW{1'b0}};
               exp_q.push_back({e_last, e_hi, e_lo});
            end
            got = {bus.out_last, bus.out_data};
            if (bus.out_valid) begin
               if (hold_ok) begin
                  checks++;
                  if (bus.out_data !== hold_data) begin
                     errors++;
                     $display("FAIL out_stable got %h required %h", bus.out_data, hold_data);
                  end
               end
               if (bus.out_ready) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL out_beat got %h required none", got);
                  end else begin
                     exp = exp_q.pop_front();
                     if (got !== exp) begin
                        errors++;
                        $display("FAIL out_beat got %h required %h", got, exp);
                     end
                  end
                  if (n_out == 0) first_data = bus.out_data;
                  upper_or = upper_or | bus.out_data[2*DW-1:DW];
                  n_out++;
                  if (bus.out_last) n_last++;
                  hold_ok = 1'b0;
               end else begin
                  hold_data = bus.out_data;
                  hold_ok   = 1'b1;
               end
            end else begin
               hold_ok = 1'b0;
            end
         end
         @(posedge clk);
         #1;
         if (fire) beat_idx++;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_start(input logic [PORT_W-1:0] p0, input logic [PORT_W-1:0] p1,
                           input bit dual, input int beats);
      n_out = 0; n_last = 0; en0_seen = 1'b0; en1_seen = 1'b0;
      upper_or = '0; first_data = '0; hold_ok = 1'b0;
      beats_m = beats; dual_m = dual; beat_idx = 0;
      step();
      cfg_port0 = p0; cfg_port1 = p1; cfg_dual = dual; cfg_beats = CNT_W'(beats);
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (run_done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      #2;
      checks++;
      if ({busy, run_done, err, bus.out_valid, bus.out_last, bus.recv_en0, bus.recv_en1} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b required 0", {busy, run_done, err, bus.out_valid,
                  bus.out_last, bus.recv_en0, bus.recv_en1});
      end
      checks++;
      if (bus.out_data !== '0 || {bus.recv_port_r0, bus.recv_port_r1} !== '0) begin
         errors++;
         $display("FAIL reset_data got %h/%h required 0", bus.out_data, {bus.recv_port_r0, bus.recv_port_r1});
      end
      checks++;
      if (dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_state got %0d required %0d", dbg_state, ST_IDLE);
      end
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_basic_dual();
      bit ok;
      base0 = 32'h10; base1 = 32'h20;
      bus.out_ready = 1'b1; bus.recv_stall = 1'b0;
      do_start(5'd4, 5'd9, 1'b1, 3);
      @(negedge clk);
      checks++;
      if ({bus.recv_port_r0, bus.recv_port_r1, busy} !== {5'd4, 5'd9, 1'b1}) begin
         errors++;
         $display("FAIL basic_ports got %0d/%0d busy %b required 4/9 busy 1",
                  bus.recv_port_r0, bus.recv_port_r1, busy);
      end
      wait_done(30, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_done got no run_done required pulse"); end
      checks++;
      if (n_out != 3 || n_last != 1) begin
         errors++;
         $display("FAIL basic_count got %0d beats %0d last required 3 beats 1 last", n_out, n_last);
      end
      checks++;
      if (first_data !== 64'h00000020_00000010) begin
         errors++;
         $display("FAIL basic_first got %h required 0000002000000010", first_data);
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b required 0", busy); end
      @(negedge clk);
      checks++;
      if (run_done !== 1'b0 || dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL basic_pulse got run_done %b state %0d required 0/%0d", run_done, dbg_state, ST_IDLE);
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL basic_left got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_single_port();
      bit ok;
      base0 = DW'($urandom); base1 = 32'hDEAD_BEEF;
      do_start(5'd3, 5'd7, 1'b0, 2);
      wait_done(30, ok);
      checks++;
      if (!ok || n_out != 2 || n_last != 1) begin
         errors++;
         $display("FAIL single_count got ok %b %0d beats %0d last required 1/2/1", ok, n_out, n_last);
      end
      checks++;
      if (en1_seen) begin errors++; $display("FAIL single_en1 got 1 required 0"); end
      checks++;
      if (upper_or !== '0) begin errors++; $display("FAIL single_upper got %h required 0", upper_or); end
   endtask

   task automatic test_stall();
      bit ok;
      base0 = DW'($urandom); base1 = DW'($urandom);
      do_start(5'd12, 5'd17, 1'b1, 6);
      step();
      bus.recv_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.recv_en0, bus.recv_en1, bus.recv_port_r0, bus.recv_port_r1} !== {2'b11, 5'd12, 5'd17}) begin
            errors++;
            $display("FAIL stall_hold got %b/%0d/%0d required 11/12/17", {bus.recv_en0, bus.recv_en1},
                     bus.recv_port_r0, bus.recv_port_r1);
         end
         if (i > 0) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_write got valid 1 required 0"); end
         end
      end
      step();
      bus.recv_stall = 1'b0;
      wait_done(40, ok);
      checks++;
      if (!ok || n_out != 6 || n_last != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL stall_count got ok %b %0d beats %0d last %0d left required 1/6/1/0",
                  ok, n_out, n_last, exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      base0 = DW'($urandom); base1 = DW'($urandom);
      bus.out_ready = 1'b0;
      do_start(5'd1, 5'd2, 1'b1, 8);
      repeat (12) @(negedge clk);
      checks++;
      if (beat_idx != DEPTH || bus.recv_en0 !== 1'b0 || bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_full got %0d beats en0 %b valid %b required %0d/0/1",
                  beat_idx, bus.recv_en0, bus.out_valid, DEPTH);
      end
      step();
      bus.out_ready = 1'b1;
      wait_done(60, ok);
      checks++;
      if (!ok || n_out != 8 || n_last != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bp_count got ok %b %0d beats %0d last %0d left required 1/8/1/0",
                  ok, n_out, n_last, exp_q.size());
      end
   endtask

   task automatic test_zero_beats();
      do_start(5'd0, 5'd0, 1'b0, 0);
      @(negedge clk);
      checks++;
      if (run_done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_done got run_done %b busy %b required 1/0", run_done, busy);
      end
      @(negedge clk);
      checks++;
      if (run_done !== 1'b0 || en0_seen || n_out != 0) begin
         errors++;
         $display("FAIL zero_quiet got run_done %b en0 %b out %0d required 0/0/0", run_done, en0_seen, n_out);
      end
   endtask

   task automatic test_reset_mid_run();
      bit ok;
      base0 = DW'($urandom); base1 = DW'($urandom);
      bus.out_ready = 1'b0;
      do_start(5'd6, 5'd8, 1'b1, 6);
      repeat (3) step();
      rst = 1'b0;
      #1;
      checks++;
      if ({busy, run_done, bus.out_valid, bus.out_last, bus.recv_en0, bus.recv_en1} !== 6'b0 ||
          bus.out_data !== '0 || {bus.recv_port_r0, bus.recv_port_r1} !== '0 || dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL midrst_zero got ctrl %b data %h state %0d required 0/0/%0d",
                  {busy, run_done, bus.out_valid, bus.out_last, bus.recv_en0, bus.recv_en1},
                  bus.out_data, dbg_state, ST_IDLE);
      end
      exp_q.delete();
      beat_idx = 0;
      hold_ok = 1'b0;
      step();
      rst = 1'b1;
      bus.out_ready = 1'b1;
      do_start(5'd2, 5'd5, 1'b1, 5);
      wait_done(40, ok);
      checks++;
      if (!ok || n_out != 5 || n_last != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL midrst_rerun got ok %b %0d beats %0d last %0d left required 1/5/1/0",
                  ok, n_out, n_last, exp_q.size());
      end
   endtask

`ifdef DYSER_RECV_TIMEOUT_EN
   task automatic test_timeout();
      bit            ok, seen;
      int            stall_cyc;
      logic [2*DW:0] tail;
      base0 = DW'($urandom); base1 = DW'($urandom);
      bus.out_ready = 1'b0;
      do_start(5'd3, 5'd4, 1'b1, 4);
      step();
      bus.recv_stall = 1'b1;
      seen = 1'b0;
      stall_cyc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (err) begin
            seen = 1'b1;
            break;
         end
         if (bus.recv_en0 && bus.recv_stall) stall_cyc++;
      end
      checks++;
      if (!seen || stall_cyc != TO_CYC || bus.recv_en0 !== 1'b0) begin
         errors++;
         $display("FAIL to_err got err %b after %0d stalls en0 %b required 1/%0d/0",
                  seen, stall_cyc, bus.recv_en0, TO_CYC);
      end
      checks++;
      if (exp_q.size() != 1) begin
         errors++;
         $display("FAIL to_captured got %0d required 1", exp_q.size());
      end else begin
         tail = exp_q.pop_back();
         tail[2*DW] = 1'b1;
         exp_q.push_back(tail);
      end
      step();
      bus.out_ready = 1'b1;
      wait_done(20, ok);
      checks++;
      if (!ok || n_out != 1 || n_last != 1 || err !== 1'b1) begin
         errors++;
         $display("FAIL to_drain got ok %b %0d beats %0d last err %b required 1/1/1/1",
                  ok, n_out, n_last, err);
      end
      bus.recv_stall = 1'b0;
   endtask
`endif

   initial begin
      bus.recv_stall = 1'b0;
      bus.out_ready  = 1'b0;
      test_reset();
      test_basic_dual();
      test_single_port();
      test_stall();
      test_backpressure();
      test_zero_beats();
      test_reset_mid_run();
`ifdef DYSER_RECV_TIMEOUT_EN
      test_timeout();
`endif
      repeat (2) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dyser_recv_collector.md
Name: dyser_recv_collector

Overview:
- Downstream consumer of the 5x5 dual-port-out DySER fabric.
- Drives the fabric's two receive ports for a programmed number of result beats.
- Captures each completed pair of results into a small FIFO and presents them to the host side as a valid/ready stream.
- Decouples host back-pressure from fabric recv stalls, so results are never lost.

Parameters:
- DW, 32, result word width; equals `DATA_WIDTH+1.
- DEPTH, 4, collector FIFO depth in beats; power of two, at least 2.
- CNT_W, 16, width of the beat counter.
- TIMEOUT_CYC, 1024, stall watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a collection run (ignored unless in IDLE).
- cfg_port0  in  5  fabric output port read through recv port 0.
- cfg_port1  in  5  fabric output port read through recv port 1.
- cfg_dual  in  1  1 = read both ports per beat; 0 = read port 0 only.
- cfg_beats  in  CNT_W  number of beats to collect; 0 = run completes immediately.
- recv_port_r0  out  5  to fabric.
- recv_port_r1  out  5  to fabric.
- recv_en0  out  1  to fabric.
- recv_en1  out  1  to fabric.
- recv_stall  in  1  from fabric.
- recv_data_r0  in  DW  from fabric.
- recv_data_r1  in  DW  from fabric.
- out_valid  out  1  host stream valid.
- out_ready  in  1  host stream ready.
- out_data  out  2*DW  {r1, r0}; r1 field is zero when cfg_dual=0.
- out_last  out  1  marks the final beat of a run.
- busy  out  1  high from start acceptance until the run completes.
- run_done  out  1  one-cycle pulse at run completion.
- err  out  1  sticky timeout flag (optional feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; FIFO empty; counters 0.
  - All outputs 0: recv_en*, recv_port*, out_*, busy, run_done, err.
  - Reset mid-run discards FIFO contents and any in-flight beat.
- Start acceptance:
  - start in IDLE latches cfg_port0/1, cfg_dual and cfg_beats, sets busy, and moves to RECV.
  - If cfg_beats=0, the FSM goes IDLE->DONE instead.
- RECV state:
  - recv_port_r0/1 drive the latched ports.
  - recv_en0 = (slots_free>0).
  - recv_en1 = recv_en0 & dual.
  - slots_free = DEPTH - fifo_count. A beat is issued only with a guaranteed FIFO slot, so there is no overflow path.
- Beat completion:
  - A beat completes in a cycle where recv_en0=1 and recv_stall=0.
  - In that same cycle, recv_data_r0/r1 are written into the FIFO (r1 masked to 0 if !dual), and beats_left decrements.
  - If recv_en0=1 and recv_stall=1, ports and enables are held unchanged and nothing is written.
- RECV->DRAIN: on the cycle the last beat completes (beats_left==1 and the beat completes). recv_en* drop the next cycle.
- DRAIN state:
  - The FSM waits until the FIFO is empty.
  - out_last is asserted with the final FIFO entry; the final-entry marker is stored as a FIFO side bit.
- DRAIN->DONE: when the FIFO is empty.
- DONE state: run_done=1 for one cycle, busy cleared, then IDLE.
- Output stream:
  - out_valid = FIFO non-empty. A pop occurs when out_valid & out_ready.
  - Simultaneous push and pop in one cycle is supported; the count is unchanged.
  - out_data must stay stable while valid & !ready.
  - FIFO is first-word-fall-through: read latency 0, write-to-visible latency 1 cycle.
- Throughput: 1 beat per cycle when the fabric is not stalling and the host is always ready.
- Counters wrap: FIFO pointers are log2(DEPTH)-bit and wrap naturally. beats_left never underflows because of the RECV exit rule.
- start while busy is ignored.

Optional Feature:
- Macro: DYSER_RECV_TIMEOUT_EN.
- With the macro defined:
  - A stall counter counts consecutive cycles with recv_en0=1 and recv_stall=1; it resets on any completed beat or on leaving RECV.
  - On reaching TIMEOUT_CYC, err is set (sticky until reset or the next accepted start), recv_en* drop, and the FSM goes to DRAIN.
  - Already-captured entries drain normally. out_last is asserted on the last stored entry, or, if the FIFO is empty, the FSM goes directly to DONE.
- Without the macro: no counter is built, err is tied 0, and the block waits indefinitely.

Decomposition:
- Shared package dyser_recv_pkg holds:
  - FSM state encoding (IDLE, RECV, DRAIN, DONE).
  - Port-index width constant (5).
  - Default TIMEOUT_CYC value.
- One natural sub-module, recv_fifo: synchronous first-word-fall-through FIFO of width 2*DW+1 (data plus last bit), depth DEPTH, with count output.

Test Plan:
- Basic dual run:
  - Stimulus: cfg_beats=3, cfg_dual=1, ports 4/9, no stall, out_ready=1, fabric returns r0=0x10,0x11,0x12 and r1=0x20,0x21,0x22.
  - Required: out_data sequence {0x20,0x10},{0x21,0x11},{0x22,0x12}; out_last only on the third beat; run_done pulse; busy low afterwards.
- Single-port run:
  - Stimulus: cfg_dual=0, cfg_beats=2.
  - Required: recv_en1 never asserted; upper DW bits of out_data are 0.
- Fabric stall:
  - Stimulus: recv_stall=1 for 5 cycles mid-run.
  - Required: recv_port* and recv_en* held; no FIFO write during the stall; beat count still exact.
- Host back-pressure:
  - Stimulus: out_ready=0, cfg_beats=8, DEPTH=4.
  - Required: exactly 4 beats captured, then recv_en0=0. Raising out_ready resumes the run; all 8 beats are delivered in order with no loss or duplication.
- Edge and reset cases:
  - Stimulus: cfg_beats=0.
  - Required: run_done in 2 cycles, no recv_en.
  - Stimulus: rst=0 asserted mid-run.
  - Required: all outputs 0 immediately; after release, a new start runs cleanly.
- Timeout (DYSER_RECV_TIMEOUT_EN, TIMEOUT_CYC=16):
  - Stimulus: permanent stall after 1 beat.
  - Required: err=1 after 16 stall cycles; 1 beat is delivered with out_last=1; run_done is pulsed.
